// File: rtl/sync_fifo_thresh.sv
// Synchronous FIFO with registered read data, occupancy count,
// programmable almost-full / almost-empty thresholds and sticky
// overflow / underflow error flags.
module sync_fifo_thresh #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status flags come only from the registered count, so they never
  // react combinationally to w_en / r_en.
  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  // Storage array; deliberately not reset, stale entries are unreachable
  // once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Write pointer advances on accepted writes; DEPTH is a power of two,
  // so the natural wrap of AW bits gives modulo-DEPTH addressing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Read pointer and registered read data; data_out holds when no read
  // is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      data_out <= '0;
    end else if (rd_ok) begin
      rd_ptr   <= rd_ptr + AW'(1);
      data_out <= mem[rd_ptr];
    end
  end

  // Occupancy: moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a fresh error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Bench for sync_fifo_thresh: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sync_fifo_thresh;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  sync_fifo_thresh #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the last value read.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf, m_unf;

  always @(posedge clk or negedge rst_n) begin
    bit wa, ra;
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      wa = w_en && (q.size() < DEPTH);
      ra = r_en && (q.size() > 0);
      if (w_en && !wa) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (r_en && !ra) m_unf = 1'b1;
      else if (err_clr) m_unf = 1'b0;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(data_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_count",    32'(count),        32'(q.size()));
      chk("m_full",     32'(full),         32'(q.size() == DEPTH));
      chk("m_empty",    32'(empty),        32'(q.size() == 0));
      chk("m_afull",    32'(almost_full),  32'(q.size() >= AF));
      chk("m_aempty",   32'(almost_empty), 32'(q.size() <= AE));
      chk("m_dout",     32'(data_out),     32'(m_dout));
      chk("m_overflow", 32'(overflow),     32'(m_ovf));
      chk("m_underflow",32'(underflow),    32'(m_unf));
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    w_en = w; data_in = d; r_en = r; err_clr = c;
    @(posedge clk);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_dout"},  32'(data_out), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_aempty"},32'(almost_empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
    chk({tag, "_unf"},   32'(underflow), 0);
  endtask

  // Reset asserted a little after a falling edge, released on a falling edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();
    cmp_on = 1'b1;

    // Fill
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      if (i == 2) chk("fill_ae2", 32'(almost_empty), 1);
      if (i == 3) chk("fill_ae3", 32'(almost_empty), 0);
      if (i == 5) chk("fill_af5", 32'(almost_full), 0);
      if (i == 6) chk("fill_af6", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);
    chk("model_size_full", 32'(q.size()), 8);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_ovf_count", 32'(count), 8);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("drain_dout", 32'(data_out), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_unf", 32'(underflow), 1);
    chk("drain_hold", 32'(data_out), 8'h08);
    chk("model_dout_hold", 32'(m_dout), 8'h08);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_both", 32'({overflow, underflow}), 0);

    // Concurrency at count 4
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'h31 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, DW'(8'h35 + i), 1'b1, 1'b0);
      chk("conc_count", 32'(count), 4);
      chk("conc_dout", 32'(data_out), 32'(8'h31 + i));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("conc_drain", 32'(data_out), 32'(8'h36 + i));
    end
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("empty_wr_count", 32'(count), 1);
    chk("empty_wr_unf", 32'(underflow), 1);
    chk("empty_wr_dout", 32'(data_out), 8'h39);
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    chk("conc_full", 32'(full), 1);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_rw_count", 32'(count), 7);
    chk("full_rw_ovf", 32'(overflow), 1);
    chk("full_rw_dout", 32'(data_out), 8'h55);

    // Error clear
    cyc(1'b1, 8'h88, 1'b0, 1'b0);
    chk("ec_full", 32'(full), 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ec_ovf_clr", 32'(overflow), 0);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk("ec_set_wins", 32'(overflow), 1);

    // Wrap
    do_reset();
    cyc(1'b1, 8'h10, 1'b0, 1'b0);
    chk("first_write", 32'(count), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_dout", 32'(data_out), 8'h10);
    for (int i = 1; i < 20; i++) begin
      cyc(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_dout", 32'(data_out), 32'(8'h10 + i));
    end
    chk("wrap_flags", 32'({overflow, underflow}), 0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    chk("mid_count5", 32'(count), 5);
    do_reset();
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_dout", 32'(data_out), 8'hAA);
    chk("post_rst_empty", 32'(empty), 1);

    // Random traffic with write/read bias changing per phase
    for (int ph = 0; ph < 40; ph++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int k = 0; k < 50; k++) begin
        cyc(1'($urandom_range(0, 99) < wp), DW'($urandom),
            1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
